// File: rtl/mem_block_responder_if.sv
// Cache-miss bus between the cache controller (master) and the block memory responder (slave).
interface mem_block_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BEAT_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [BEAT_W-1:0] beat;
  logic              done;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, wr_data,
    input  req_ready, wr_ready, rd_data, rd_valid, beat, done, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, wr_data,
    output req_ready, wr_ready, rd_data, rd_valid, beat, done, busy
  );
endinterface

// File: rtl/mem_block_responder.sv
// Main-memory responder: accepts a block read/write, waits LATENCY cycles,
// then moves one word per cycle in ascending order with done on the last beat.
module mem_block_responder #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int LATENCY         = 4,
  parameter int MEM_WORDS       = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_block_responder_if.slave bus
);
  localparam int BEAT_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W  = BEAT_W + 2;
  localparam int BASE_W = ADDR_W - OFF_W;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  LAT_M1    = CNT_W'(LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  // Words are stored XORed with their own index, so the all-zero power-up
  // state of the array reads back as word k = k.
  logic [DATA_W-1:0]   mem_q [MEM_WORDS];
  logic [BEAT_W-1:0]   beat_nxt;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic [DATA_W-1:0]   rd_word;
  logic                wr_en;
  logic                unused_addr_bits;

  assign beat_nxt = (state_q == S_XFER) ? beat_q + BEAT_W'(1) : '0;
  assign rd_idx   = {base_q, beat_nxt};
  assign wr_idx   = {base_q, beat_q};
  assign rd_word  = mem_q[rd_idx] ^ DATA_W'(rd_idx);
  assign wr_en    = (state_q == S_XFER) && write_q;
  assign unused_addr_bits = ^bus.req_addr[OFF_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    base_d    = base_q;
    write_d   = write_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          base_d  = bus.req_addr[ADDR_W-1:OFF_W];
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_XFER;
          beat_d  = '0;
          if (!write_q) rd_data_d = rd_word;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_XFER: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_nxt;
          if (!write_q) rd_data_d = rd_word;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      base_q    <= '0;
      write_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      write_q   <= write_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= bus.wr_data ^ DATA_W'(wr_idx);
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rd_valid  = (state_q == S_XFER) && !write_q;
  assign bus.wr_ready  = wr_en;
  assign bus.done      = (state_q == S_XFER) && (beat_q == LAST_BEAT);
  assign bus.beat      = beat_q;
  assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder: vector table of block transactions
// plus hand sequences for busy-ignore, back-to-back, reset mid-write and LATENCY=1.
module tb_mem_block_responder;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_block_responder_if #(.ADDR_W(AW), .DATA_W(DW), .BEAT_W(2)) b4 ();
  mem_block_responder_if #(.ADDR_W(AW), .DATA_W(DW), .BEAT_W(2)) b1 ();

  mem_block_responder #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(4),
                        .LATENCY(4), .MEM_WORDS(256))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  mem_block_responder #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(4),
                        .LATENCY(1), .MEM_WORDS(256))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic             wr;
    logic [AW-1:0]    addr;
    logic [3:0][31:0] d;   // write data, or expected read data
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic wr, input logic [AW-1:0] addr,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
    vec_t v;
    v.wr   = wr;
    v.addr = addr;
    v.d[0] = d0;
    v.d[1] = d1;
    v.d[2] = d2;
    v.d[3] = d3;
    return v;
  endfunction

  // One full transaction on the LATENCY=4 instance, checked cycle by cycle.
  task automatic txn4(input vec_t v, input bit pulse_mid, input bit hold,
                      input logic [AW-1:0] next_addr);
    chk("idle_ready", 32'(b4.req_ready), 1);
    b4.req_valid = 1'b1;
    b4.req_write = v.wr;
    b4.req_addr  = v.addr;
    step();
    if (hold) b4.req_addr = next_addr;
    else      b4.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pulse_mid && i == 1) begin
        b4.req_valid = 1'b1;
        b4.req_addr  = 10'h100;
      end
      if (pulse_mid && i == 2) b4.req_valid = 1'b0;
      chk("wait_busy", 32'(b4.busy), 1);
      chk("wait_ready", 32'(b4.req_ready), 0);
      chk("wait_quiet", 32'({b4.rd_valid, b4.wr_ready, b4.done}), 0);
      step();
    end
    for (int b = 0; b < 4; b++) begin
      if (v.wr) b4.wr_data = v.d[b];
      chk("xfer_beat", 32'(b4.beat), 32'(b));
      chk("xfer_done", 32'(b4.done), (b == 3) ? 1 : 0);
      chk("xfer_ready", 32'(b4.req_ready), 0);
      if (v.wr) begin
        chk("wr_ready", 32'(b4.wr_ready), 1);
        chk("wr_no_rdv", 32'(b4.rd_valid), 0);
      end else begin
        chk("rd_valid", 32'(b4.rd_valid), 1);
        chk("rd_no_wrr", 32'(b4.wr_ready), 0);
        chk("rd_data", b4.rd_data, v.d[b]);
      end
      step();
    end
    b4.wr_data = '0;
    chk("end_ready", 32'(b4.req_ready), 1);
    chk("end_busy", 32'(b4.busy), 0);
    chk("end_quiet", 32'({b4.rd_valid, b4.wr_ready, b4.done}), 0);
    chk("end_beat", 32'(b4.beat), 0);
    if (!v.wr) chk("rd_hold", b4.rd_data, v.d[3]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b4.req_valid = 1'b0; b4.req_write = 1'b0; b4.req_addr = '0; b4.wr_data = '0;
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.wr_data = '0;

    vecs[0] = mkv(1'b0, 10'h040, 32'd16, 32'd17, 32'd18, 32'd19);
    vecs[1] = mkv(1'b1, 10'h080, 32'hAAAA0000, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003);
    vecs[2] = mkv(1'b0, 10'h080, 32'hAAAA0000, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003);
    vecs[3] = mkv(1'b0, 10'h090, 32'd36, 32'd37, 32'd38, 32'd39);
    vecs[4] = mkv(1'b0, 10'h04C, 32'd16, 32'd17, 32'd18, 32'd19);
    vecs[5] = mkv(1'b0, 10'h3F0, 32'd252, 32'd253, 32'd254, 32'd255);
    vecs[6] = mkv(1'b1, 10'h00F, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h12345678);
    vecs[7] = mkv(1'b0, 10'h000, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h12345678);

    #2;
    chk("rst_ready", 32'(b4.req_ready), 1);
    chk("rst_busy", 32'(b4.busy), 0);
    chk("rst_quiet", 32'({b4.rd_valid, b4.wr_ready, b4.done}), 0);
    chk("rst_rd_data", b4.rd_data, 0);
    chk("rst_beat", 32'(b4.beat), 0);
    chk("rst_l1_ready", 32'(b1.req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 8; k++) txn4(vecs[k], 1'b0, 1'b0, '0);

    // Request pulsed mid-WAIT must be dropped.
    txn4(mkv(1'b0, 10'h090, 32'd36, 32'd37, 32'd38, 32'd39), 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      chk("ignore_busy", 32'(b4.busy), 0);
      chk("ignore_done", 32'(b4.done), 0);
      step();
    end

    // Held req_valid: second request taken on the first IDLE cycle.
    txn4(mkv(1'b0, 10'h040, 32'd16, 32'd17, 32'd18, 32'd19), 1'b0, 1'b1, 10'h050);
    txn4(mkv(1'b0, 10'h050, 32'd20, 32'd21, 32'd22, 32'd23), 1'b0, 1'b0, '0);

    // Reset after the second write beat: beats 0 and 1 land, 2 and 3 do not.
    b4.req_valid = 1'b1; b4.req_write = 1'b1; b4.req_addr = 10'h0C0;
    step();
    b4.req_valid = 1'b0;
    repeat (4) step();
    b4.wr_data = 32'h11;
    step();
    b4.wr_data = 32'h22;
    step();
    chk("pre_rst_beat", 32'(b4.beat), 2);
    chk("pre_rst_rd_data", b4.rd_data, 23);
    b4.wr_data = 32'h33;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(b4.req_ready), 1);
    chk("mid_rst_busy", 32'(b4.busy), 0);
    chk("mid_rst_quiet", 32'({b4.rd_valid, b4.wr_ready, b4.done}), 0);
    chk("mid_rst_beat", 32'(b4.beat), 0);
    chk("mid_rst_rd_data", b4.rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b4.wr_data = '0;
    step();
    txn4(mkv(1'b0, 10'h0C0, 32'h11, 32'h22, 32'd50, 32'd51), 1'b0, 1'b0, '0);

    // LATENCY=1 instance: one WAIT cycle, beats at T+2..T+5.
    b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = 10'h040;
    step();
    b1.req_valid = 1'b0;
    chk("l1_wait_busy", 32'(b1.busy), 1);
    chk("l1_wait_rdv", 32'(b1.rd_valid), 0);
    step();
    for (int b = 0; b < 4; b++) begin
      chk("l1_rd_valid", 32'(b1.rd_valid), 1);
      chk("l1_beat", 32'(b1.beat), 32'(b));
      chk("l1_rd_data", b1.rd_data, 32'(16 + b));
      chk("l1_done", 32'(b1.done), (b == 3) ? 1 : 0);
      step();
    end
    chk("l1_end_ready", 32'(b1.req_ready), 1);
    chk("l1_end_busy", 32'(b1.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_block_responder.md
Name: mem_block_responder

Overview:
- Clocked main-memory responder; the memory end of the cache-miss interface.
- Services block-granular read and write requests from the cache controller after a fixed access latency.
- Transfers one 32-bit word per cycle and signals completion with a one-cycle done pulse.
- Replaces the combinational memory model behind the cache, so miss timing becomes cycle-accurate.

Parameters:
- ADDR_W, 10, byte-address width (1 KiB physical space).
- DATA_W, 32, word width.
- WORDS_PER_BLOCK, 4, words per cache block (block = 16 bytes).
- LATENCY, 4, wait cycles between request accept and first beat; legal range is at least 1.
- MEM_WORDS, 256, storage depth, equal to 2^(ADDR_W-2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  cache presents a request.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_write  input  1  1 = block write-back, 0 = block fill; sampled on accept.
- req_addr  input  ADDR_W  byte address; sampled on accept; bits [3:0] ignored.
- wr_data  input  DATA_W  write word for the current beat.
- wr_ready  output  1  responder samples wr_data this cycle (write beats).
- rd_data  output  DATA_W  read word for the current beat.
- rd_valid  output  1  rd_data valid this cycle (read beats).
- beat  output  2  word index within the block for the current beat.
- done  output  1  one-cycle pulse coinciding with the final beat.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): state goes to IDLE. req_ready=1. wr_ready, rd_valid, done and busy are 0. rd_data=0, beat=0, wait counter=0.
- Storage contents are not affected by reset. Power-up content is word k = k, zero-extended.
- FSM states: IDLE, WAIT, XFER.
- IDLE: on req_valid && req_ready at edge T:
  - latch req_write and block base = req_addr[ADDR_W-1:4];
  - load counter = LATENCY-1;
  - go to WAIT.
- req_valid outside IDLE is ignored; no queueing.
- WAIT: counter decrements each cycle. When the counter is 0, go to XFER with beat=0. WAIT therefore occupies cycles T+1..T+LATENCY.
- XFER: one beat per cycle, beat 0..3, always in ascending word order. Word index = {base, beat}. No backpressure in either direction.
  - Read beat: rd_valid=1; rd_data = mem[{base,beat}], driven from a register.
  - Write beat: wr_ready=1; mem[{base,beat}] <= wr_data at that edge. The cache must hold the word for the current beat whenever wr_ready is high.
  - beat 3: done=1 in the same cycle; next state is IDLE.
- Timing: first beat at cycle T+LATENCY+1, done at T+LATENCY+4. req_ready is high again at T+LATENCY+5.
- Back-to-back: if req_valid is held high, the next request is accepted on the first IDLE cycle after done.
- Outside their beats, rd_valid, wr_ready and done are 0. rd_data holds its last value. beat is 0 outside XFER.
- Reset during WAIT: no memory change.
- Reset during a write XFER: beats already written persist and later beats are not written (partial block is permitted). The cache must reissue the request.
- Reset during a read XFER: the read is aborted and no done is issued.
- Addressing: req_addr[1:0] and [3:2] are don't-care. Any address inside a block selects the same block.

Test Plan:
- Read fill: LATENCY=4, accept 0x040 at T -> rd_valid at T+5..T+8 with rd_data 16,17,18,19 and beat 0..3; done only at T+8; req_ready=0 over T+1..T+8.
- Write-back then readback: write 0x080 with words 0xAAAA0000..0xAAAA0003 on wr_ready beats, then read 0x080 -> returns 0xAAAA0000..0xAAAA0003. Neighbouring block 0x090 still reads 36..39.
- Offset aliasing: read 0x04C -> same data as 0x040 (16..19), beats still start at word 0.
- Busy ignore and back-to-back: pulse req_valid for 0x100 mid-WAIT of another request -> ignored, no extra done. Hold req_valid for two requests -> second accepted exactly one cycle after the first done.
- Reset mid-write: write 0x0C0 with 0x11,0x22,0x33,0x44 and assert rst_n=0 after beat 1's edge -> outputs clear immediately. A subsequent read of 0x0C0 returns 0x11,0x22,50,51.
- LATENCY=1 build: accept at T -> beats at T+2..T+5, done at T+5.
